// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the bitmap store engine state encoding.
package cpu_pkg;

  localparam int unsigned BM_W     = 1536;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned BM_WORDS = BM_W / WORD_W;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned BM_SEL_W = 2;
  localparam int unsigned CNT_W    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } bm_store_state_t;

  // Select 3 aliases register 0, matching the register file decode.
  function automatic logic [BM_SEL_W-1:0] bm_sel_decode(input logic [BM_SEL_W-1:0] sel);
    return (sel == BM_SEL_W'(3)) ? BM_SEL_W'(0) : sel;
  endfunction

endpackage

// File: rtl/bm_shift_out.sv
// Parallel-load register that shifts right by one memory word per request.
module bm_shift_out #(
  parameter int unsigned B = 1536,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [B-1:0] par_in,
  output logic [W-1:0] word_out
);

  logic [B-1:0] sh_q;
  logic [B-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = par_in;
    end else if (shift) begin
      sh_d = {{W{1'b0}}, sh_q[B-1:W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign word_out = sh_q[W-1:0];

endmodule

// File: rtl/bm_store_unit.sv
// Bitmap store engine: snapshots one bitmap register and streams it to memory
// as consecutive words over a valid/ready write port.
module bm_store_unit
  import cpu_pkg::*;
#(
  parameter int unsigned B  = BM_W,
  parameter int unsigned W  = WORD_W,
  parameter int unsigned AW = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BM_SEL_W-1:0] bm_sel,
  input  logic [AW-1:0]       base_addr,
  output logic                busy,
  output logic                done,
  output logic [BM_SEL_W-1:0] rbm_addr,
  input  logic [B-1:0]        rbm_data,
  output logic [AW-1:0]       mem_addr,
  output logic [W-1:0]        mem_wdata,
  output logic                mem_wr,
  input  logic                mem_ready
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BM_WORDS - 1);

  bm_store_state_t     state_q, state_d;
  logic [BM_SEL_W-1:0] sel_q, sel_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_q, wr_d;
  logic                sh_load;
  logic                sh_shift;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_d     = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = bm_sel_decode(bm_sel);
          addr_d  = base_addr;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sh_load = 1'b1;
        wr_d    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        wr_d = 1'b1;
        if (mem_ready) begin
          sh_shift = 1'b1;
          addr_d   = addr_q + AW'(1);
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WORD) begin
            wr_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
    end
  end

  bm_shift_out #(
    .B (B),
    .W (W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .shift    (sh_shift),
    .par_in   (rbm_data),
    .word_out (mem_wdata)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rbm_addr = sel_q;
  assign mem_addr = addr_q;
  assign mem_wr   = wr_q;

endmodule
